fpu_add_ctrl: RTL and testbench
===============================

FPU_ADD_CTRL -- requirements
Module: fpu_add_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8: number of WAIT cycles allowed before a timeout error.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port address, input, 4: register select (0x0 A, 0x4 B, 0x8 CTRL/STATUS, 0xC RESULT).
REQ-005 SHALL have port data_in, input, 32: bus write data.
REQ-006 SHALL have port data_write, input, 1: one-cycle write strobe.
REQ-007 SHALL have port data_read, input, 1: one-cycle read strobe.
REQ-008 SHALL have port data_out, output, 32: combinational read mux of the register selected by address.
REQ-009 SHALL have port fpu_valid_in, output, 1: issue strobe to the adder.
REQ-010 SHALL have ports fpu_a and fpu_b, output, 32 each: adder operands.
REQ-011 SHALL have port fpu_valid_out, input, 1: adder completion strobe.
REQ-012 SHALL have port fpu_result, input, 32: adder result, valid with fpu_valid_out.
REQ-013 SHALL have port irq, output, 1: completion interrupt.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-015 In IDLE or DONE, a write to CTRL with data_in[0]=1 SHALL enter ISSUE on the next edge, clear done and error, and latch op = data_in[1].
REQ-016 ISSUE SHALL last exactly one cycle with fpu_valid_in=1, then SHALL enter WAIT; fpu_valid_in SHALL be 0 in every other state.
REQ-017 fpu_a SHALL equal reg A; fpu_b SHALL equal reg B with bit 31 inverted when op=1 (subtract), else reg B unmodified.
REQ-018 In WAIT, fpu_valid_out=1 SHALL capture fpu_result into RESULT, set done and enter DONE; fpu_valid_out in any other state SHALL be ignored.
REQ-019 The WAIT counter SHALL reset on WAIT entry and increment each WAIT cycle; if it reaches TIMEOUT_CYCLES without fpu_valid_out, RESULT SHALL be 0x7FC00000, error and done SHALL be set, and the FSM SHALL enter DONE.
REQ-020 fpu_valid_out on the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: result captured, no error.
REQ-021 Writes to A, B or CTRL while in ISSUE or WAIT SHALL be ignored, with no state change.
REQ-022 A CTRL read SHALL return {29'b0, error, done, busy}; busy=1 in ISSUE and WAIT.
REQ-023 A read of RESULT (data_read=1, address 0xC) SHALL clear done on the next edge; if completion occurs in the same cycle, completion SHALL win and done SHALL stay set.
REQ-024 A and B SHALL be readable back; writes to unmapped addresses SHALL be ignored and reads SHALL return 0.
REQ-025 The nominal start-write-to-done latency with a 3-stage adder SHALL be 5 cycles (1 ISSUE + 3 adder + 1 capture).

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, A=B=RESULT=0, op=0, done=error=0, counter=0, fpu_valid_in=0, irq=0.
REQ-027 Reset during WAIT SHALL abandon the operation; a stale fpu_valid_out after release SHALL be ignored (FSM in IDLE).

Configuration
REQ-028 With FPU_ADD_CTRL_IRQ_EN defined, irq SHALL be registered: set on entry to DONE, cleared by a RESULT read or by a new start.
REQ-029 Without FPU_ADD_CTRL_IRQ_EN, irq SHALL be constant 0 and no irq flop SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-030 Add: A=0x3F800000, B=0x40000000, CTRL=0x1 -> one fpu_valid_in pulse; RESULT=0x40400000; STATUS=0x2 five cycles after start.
REQ-031 Subtract: A=0x40400000, B=0x3F800000, CTRL=0x3 -> fpu_b=0xBF800000 during ISSUE; RESULT=0x40000000.
REQ-032 Timeout: stub holds fpu_valid_out=0 -> after 8 WAIT cycles, RESULT=0x7FC00000 and STATUS=0x6.
REQ-033 Busy guard: start, then write A=0xDEADBEEF and CTRL=0x1 during WAIT -> A unchanged; exactly one fpu_valid_in pulse.
REQ-034 Reset mid-WAIT: assert rst_n=0 one cycle after ISSUE, then release; stub pulses fpu_valid_out -> STATUS=0x0, RESULT=0.
REQ-035 IRQ (macro defined): completion raises irq; a RESULT read drops irq and done on the next edge; with the macro undefined, irq stays 0 throughout.

Source files
------------

// File: rtl/fpu_add_ctrl_if.sv
// fpu_add_ctrl_if: register bus plus adder issue/complete handshake
interface fpu_add_ctrl_if;
  logic [3:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic data_write;
  logic data_read;
  logic fpu_valid_in;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic fpu_valid_out;
  logic [31:0] fpu_result;
  logic irq;
  modport slave (
    input address, data_in, data_write, data_read, fpu_valid_out, fpu_result,
    output data_out, fpu_valid_in, fpu_a, fpu_b, irq
  );
  modport master (
    output address, data_in, data_write, data_read, fpu_valid_out, fpu_result,
    input data_out, fpu_valid_in, fpu_a, fpu_b, irq
  );
endinterface

// File: rtl/fpu_add_ctrl.sv
// fpu_add_ctrl: register-mapped sequencer for a pipelined FP adder with timeout.
// Define FPU_ADD_CTRL_IRQ_EN to build the registered completion irq.
module fpu_add_ctrl #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic clk,
  input logic rst_n,
  fpu_add_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [31:0] reg_a, reg_b, result;
  logic op, done, error, valid_in;
  logic [CW-1:0] cnt;
  logic idle, busy, wr_a, wr_b, start, rd_res, timeout, finish;
  always_comb begin
    idle = state == IDLE || state == DONE;
    busy = state == ISSUE || state == WAIT;
    wr_a = bus.data_write && idle && bus.address == 4'h0;
    wr_b = bus.data_write && idle && bus.address == 4'h4;
    start = bus.data_write && idle && bus.address == 4'h8 && bus.data_in[0];
    rd_res = bus.data_read && bus.address == 4'hC;
    timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    finish = state == WAIT && (bus.fpu_valid_out || timeout);
  end
  assign bus.fpu_valid_in = valid_in;
  assign bus.fpu_a = reg_a;
  assign bus.fpu_b = {reg_b[31] ^ op, reg_b[30:0]};
  assign bus.data_out = bus.address == 4'h0 ? reg_a :
                        bus.address == 4'h4 ? reg_b :
                        bus.address == 4'h8 ? {29'b0, error, done, busy} :
                        bus.address == 4'hC ? result : 32'h0;
  // Completion updates are placed after the read-clear so a same-cycle capture keeps done set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      result <= '0;
      op <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      valid_in <= 1'b0;
      cnt <= '0;
    end else begin
      valid_in <= 1'b0;
      if (wr_a) reg_a <= bus.data_in;
      if (wr_b) reg_b <= bus.data_in;
      if (rd_res) done <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= ISSUE;
          valid_in <= 1'b1;
          op <= bus.data_in[1];
          done <= 1'b0;
          error <= 1'b0;
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: if (bus.fpu_valid_out) begin
          result <= bus.fpu_result;
          done <= 1'b1;
          state <= DONE;
        end else if (timeout) begin
          result <= 32'h7FC0_0000;
          error <= 1'b1;
          done <= 1'b1;
          state <= DONE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FPU_ADD_CTRL_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else if (finish) irq_q <= 1'b1;
    else if (rd_res || start) irq_q <= 1'b0;
  end
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_add_ctrl.sv
// tb_fpu_add_ctrl: randomized register-level checks against a latency-programmable adder stub
// and a transaction-level model of outcome (result, status, irq) per operation.
module tb_fpu_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int stub_lat = 3;
  int stub_cnt = 0;
  bit stub_pend = 1'b0;
  int kick_req = 0;
  int kick_ack = 0;
  int pulses = 0;
  logic [31:0] seen_a = '0;
  logic [31:0] seen_b = '0;
`ifdef FPU_ADD_CTRL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  fpu_add_ctrl_if bus();
  fpu_add_ctrl #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.fpu_valid_in === 1'b1) pulses <= pulses + 1;

  // Arbitrary but deterministic stand-in for FP addition, exact for the two reference vectors.
  function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h1234_5677;
  endfunction

  // Model: success iff the adder answers within the 8-cycle wait window (tie counts as success).
  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b, input logic op, input int lat);
    return (lat >= 1 && lat <= 8) ? adder_fn(a, op ? (b ^ 32'h8000_0000) : b) : 32'h7FC0_0000;
  endfunction

  function automatic logic [31:0] model_status(input int lat);
    return (lat >= 1 && lat <= 8) ? 32'h2 : 32'h6;
  endfunction

  // Adder stub: answers stub_lat cycles after an issue (0 = never); kick forces a stray completion.
  initial begin
    bus.fpu_valid_out = 1'b0;
    bus.fpu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.fpu_valid_out = 1'b0;
      if (!rst_n) stub_pend = 1'b0;
      if (stub_pend) begin
        stub_cnt = stub_cnt - 1;
        if (stub_cnt == 0) begin
          bus.fpu_valid_out = 1'b1;
          bus.fpu_result = adder_fn(seen_a, seen_b);
          stub_pend = 1'b0;
        end
      end
      if (kick_req != kick_ack) begin
        kick_ack = kick_req;
        bus.fpu_valid_out = 1'b1;
        bus.fpu_result = 32'hBAD0_BAD0;
      end
      if (bus.fpu_valid_in === 1'b1) begin
        seen_a = bus.fpu_a;
        seen_b = bus.fpu_b;
        stub_pend = stub_lat != 0;
        stub_cnt = stub_lat;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address = a;
    bus.data_in = d;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.address = a;
    bus.data_read = 1'b1;
    #1 d = bus.data_out;
    @(negedge clk);
    bus.data_read = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    bus.address = a;
    #1 d = bus.data_out;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic op);
    wr(4'h0, a);
    wr(4'h4, b);
    wr(4'h8, {30'b0, op, 1'b1});
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      n_cmp++;
      if (d !== 32'h0) begin n_bad++; $display("FAIL reset_reg%0d: got %h expected 00000000", i * 4, d); end
    end
    n_cmp++;
    if (bus.fpu_valid_in !== 1'b0 || bus.irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_outs: valid_in=%b irq=%b expected 0 0", bus.fpu_valid_in, bus.irq);
    end
  endtask

  task automatic test_add();
    logic [31:0] d;
    int p0;
    stub_lat = 3;
    wr(4'h0, 32'h3F80_0000);
    wr(4'h4, 32'h4000_0000);
    p0 = pulses;
    wr(4'h8, 32'h1);
    #1;
    n_cmp++;
    if (bus.fpu_valid_in !== 1'b1) begin n_bad++; $display("FAIL add_issue: valid_in=%b expected 1", bus.fpu_valid_in); end
    cycles(3);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL add_busy_c4: got %h expected 00000001", d); end
    cycles(1);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL add_status_c5: got %h expected 00000002", d); end
    n_cmp++;
    if (bus.irq !== IRQ_EN) begin n_bad++; $display("FAIL add_irq: got %b expected %b", bus.irq, IRQ_EN); end
    rd(4'hC, d);
    n_cmp++;
    if (d !== 32'h4040_0000) begin n_bad++; $display("FAIL add_result: got %h expected 40400000", d); end
    n_cmp++;
    if (pulses - p0 != 1) begin n_bad++; $display("FAIL add_pulses: got %0d expected 1", pulses - p0); end
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h0 || bus.irq !== 1'b0) begin n_bad++; $display("FAIL add_rdclr: status %h irq %b expected 00000000 0", d, bus.irq); end
  endtask

  task automatic test_sub();
    logic [31:0] d;
    stub_lat = 3;
    start_op(32'h4040_0000, 32'h3F80_0000, 1'b1);
    #1;
    n_cmp++;
    if (bus.fpu_b !== 32'hBF80_0000) begin n_bad++; $display("FAIL sub_fpu_b: got %h expected bf800000", bus.fpu_b); end
    cycles(6);
    rd(4'hC, d);
    n_cmp++;
    if (d !== 32'h4000_0000) begin n_bad++; $display("FAIL sub_result: got %h expected 40000000", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    stub_lat = 0;
    start_op(32'h1, 32'h2, 1'b0);
    cycles(8);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL tmo_busy_c9: got %h expected 00000001", d); end
    cycles(1);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h6) begin n_bad++; $display("FAIL tmo_status: got %h expected 00000006", d); end
    rd(4'hC, d);
    n_cmp++;
    if (d !== 32'h7FC0_0000) begin n_bad++; $display("FAIL tmo_result: got %h expected 7fc00000", d); end
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL tmo_rdclr: got %h expected 00000004", d); end
  endtask

  task automatic test_busy_guard();
    logic [31:0] d;
    int p0;
    stub_lat = 4;
    p0 = pulses;
    start_op(32'h1111_2222, 32'h3333_4444, 1'b0);
    wr(4'h0, 32'hDEAD_BEEF);
    wr(4'h8, 32'h1);
    wr(4'h4, 32'hCAFE_F00D);
    cycles(5);
    rd(4'h0, d);
    n_cmp++;
    if (d !== 32'h1111_2222) begin n_bad++; $display("FAIL guard_a: got %h expected 11112222", d); end
    rd(4'h4, d);
    n_cmp++;
    if (d !== 32'h3333_4444) begin n_bad++; $display("FAIL guard_b: got %h expected 33334444", d); end
    n_cmp++;
    if (pulses - p0 != 1) begin n_bad++; $display("FAIL guard_pulses: got %0d expected 1", pulses - p0); end
    rd(4'hC, d);
    n_cmp++;
    if (d !== model_result(32'h1111_2222, 32'h3333_4444, 1'b0, 4)) begin
      n_bad++; $display("FAIL guard_result: got %h expected %h", d, model_result(32'h1111_2222, 32'h3333_4444, 1'b0, 4));
    end
  endtask

  task automatic test_read_race();
    logic [31:0] d;
    stub_lat = 3;
    start_op(32'h0F0F_0F0F, 32'h7070_7070, 1'b0);
    cycles(3);
    rd(4'hC, d);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL race_done: got %h expected 00000002", d); end
    n_cmp++;
    if (bus.irq !== IRQ_EN) begin n_bad++; $display("FAIL race_irq: got %b expected %b", bus.irq, IRQ_EN); end
    rd(4'hC, d);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL race_rdclr: got %h expected 00000000", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, x, y;
    x = $urandom;
    y = $urandom;
    wr(4'h0, x);
    wr(4'h4, y);
    wr(4'h2, 32'hFFFF_FFFF);
    wr(4'hD, 32'hFFFF_FFFF);
    rd(4'h2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_2: got %h expected 00000000", d); end
    rd(4'hD, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_d: got %h expected 00000000", d); end
    rd(4'h0, d);
    n_cmp++;
    if (d !== x) begin n_bad++; $display("FAIL readback_a: got %h expected %h", d, x); end
    rd(4'h4, d);
    n_cmp++;
    if (d !== y) begin n_bad++; $display("FAIL readback_b: got %h expected %h", d, y); end
  endtask

  task automatic test_random();
    logic [31:0] d, a, b;
    logic op;
    int lat;
    int lats[4] = '{8, 9, 1, 0};
    for (int i = 0; i < 14; i++) begin
      a = $urandom;
      b = $urandom;
      op = 1'($urandom_range(0, 1));
      lat = i < 4 ? lats[i] : int'($urandom_range(0, 10));
      stub_lat = lat;
      start_op(a, b, op);
      cycles(12);
      peek(4'h8, d);
      n_cmp++;
      if (d !== model_status(lat)) begin n_bad++; $display("FAIL rnd%0d_status lat=%0d: got %h expected %h", i, lat, d, model_status(lat)); end
      n_cmp++;
      if (bus.irq !== IRQ_EN) begin n_bad++; $display("FAIL rnd%0d_irq: got %b expected %b", i, bus.irq, IRQ_EN); end
      rd(4'hC, d);
      n_cmp++;
      if (d !== model_result(a, b, op, lat)) begin
        n_bad++; $display("FAIL rnd%0d_result lat=%0d op=%b: got %h expected %h", i, lat, op, d, model_result(a, b, op, lat));
      end
      peek(4'h8, d);
      n_cmp++;
      if (d !== (model_status(lat) & 32'h4)) begin n_bad++; $display("FAIL rnd%0d_rdclr: got %h expected %h", i, d, model_status(lat) & 32'h4); end
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] d;
    stub_lat = 0;
    start_op(32'h5555_AAAA, 32'h1234_5678, 1'b0);
    cycles(1);
    rst_n = 1'b0;
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h0 || bus.fpu_valid_in !== 1'b0) begin n_bad++; $display("FAIL rstw_async: status %h valid_in %b expected 00000000 0", d, bus.fpu_valid_in); end
    cycles(1);
    rst_n = 1'b1;
    kick_req++;
    cycles(4);
    peek(4'h8, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rstw_status: got %h expected 00000000", d); end
    rd(4'hC, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rstw_result: got %h expected 00000000", d); end
    rd(4'h0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rstw_a: got %h expected 00000000", d); end
    n_cmp++;
    if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL rstw_irq: got %b expected 0", bus.irq); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.address = 4'h0;
    bus.data_in = '0;
    bus.data_write = 1'b0;
    bus.data_read = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_busy_guard();
    test_read_race();
    test_unmapped();
    test_random();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
